// File: rtl/rgmii_rx_frontend.sv
// RGMII receive front end: DDR/SDR capture, preamble strip, word packing.
// Optional in-band link status decode under RGMII_INBAND_STATUS_EN.
module rgmii_rx_frontend #(
  parameter int OUT_BYTES    = 4,
  parameter int MIN_PREAMBLE = 2,
  parameter int LEN_W        = 16
) (
  input  logic                   rx_clk,
  input  logic                   reset_n,
  input  logic                   speed_1g,
  input  logic [3:0]             rgmii_rxd,
  input  logic                   rgmii_rx_ctl,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   out_err,
  output logic [LEN_W-1:0]       out_len,
  output logic [2:0]             link_status
);

  localparam int DW = 8 * OUT_BYTES;
  localparam int CW = $clog2(OUT_BYTES + 1);
  localparam logic [3:0] MIN_P = 4'(MIN_PREAMBLE);
  localparam logic [CW-1:0] FULL = CW'(OUT_BYTES);

  typedef enum logic [1:0] {
    IDLE, PREAMBLE, DATA, DROP
  } state_t;

  state_t state_q, state_d;

  logic [3:0] nib_lo, nib_hi, lo_hold;
  logic ctl_r, ctl_f, half, mode_1g;
  logic stb, dv, er, odd;
  logic [7:0] rx_byte;
  logic [3:0] pcnt_q, pcnt_d;
  logic start, take, flush;
  logic [DW-1:0] acc;
  logic [CW-1:0] acc_cnt;
  logic [OUT_BYTES-1:0] keep_w;
  logic [LEN_W-1:0] len_q;
  logic err_q, sent_q;

  // rising-edge capture: low nibble and DV
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_lo <= '0;
      ctl_r  <= 1'b0;
    end else begin
      nib_lo <= rgmii_rxd;
      ctl_r  <= rgmii_rx_ctl;
    end
  end

  // falling-edge capture: high nibble and DV^ER
  always_ff @(negedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_hi <= '0;
      ctl_f  <= 1'b0;
    end else begin
      nib_hi <= rgmii_rxd;
      ctl_f  <= rgmii_rx_ctl;
    end
  end

  // speed latch in IDLE and SDR nibble phase tracking
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_1g <= 1'b1;
      half    <= 1'b0;
      lo_hold <= '0;
    end else begin
      if (state_q == IDLE)
        mode_1g <= speed_1g;
      if (!mode_1g && ctl_r) begin
        half <= ~half;
        if (!half)
          lo_hold <= nib_lo;
      end else begin
        half <= 1'b0;
      end
    end
  end

  // byte/strobe recovery for both speeds
  always_comb begin
    stb     = 1'b1;
    dv      = ctl_r;
    er      = 1'b0;
    odd     = 1'b0;
    rx_byte = {nib_hi, nib_lo};
    if (mode_1g) begin
      er = ctl_r ^ ctl_f;
    end else if (ctl_r) begin
      stb     = half;
      rx_byte = {nib_lo, lo_hold};
    end else begin
      rx_byte = {4'h0, nib_lo};
      odd     = half;
    end
  end

  // frame state register
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // next state on byte strobes
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    start   = 1'b0;
    if (stb) begin
      unique case (state_q)
        IDLE: begin
          if (dv && rx_byte == 8'h55) begin
            state_d = PREAMBLE;
            pcnt_d  = 4'd1;
          end else if (dv) begin
            state_d = DROP;
          end
        end
        PREAMBLE: begin
          if (!dv) begin
            state_d = IDLE;
          end else if (rx_byte == 8'h55) begin
            if (pcnt_q != 4'hF)
              pcnt_d = pcnt_q + 4'd1;
          end else if (rx_byte == 8'hD5 && pcnt_q >= MIN_P) begin
            state_d = DATA;
            start   = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        DATA: if (!dv) state_d = IDLE;
        DROP: if (!dv) state_d = IDLE;
      endcase
    end
  end

  assign take  = stb && dv && state_q == DATA;
  assign flush = stb && !dv && state_q == DATA;

  // lanes filled in the partial word
  always_comb begin
    keep_w = '0;
    for (int i = 0; i < OUT_BYTES; i++)
      keep_w[i] = CW'(i) < acc_cnt;
  end

  // packing, pending word and output register
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      acc_cnt   <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      sent_q    <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= '0;
    end else begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= '0;
      if (start) begin
        acc     <= '0;
        acc_cnt <= '0;
        len_q   <= '0;
        err_q   <= 1'b0;
        sent_q  <= 1'b0;
      end
      if (take) begin
        err_q <= err_q | er;
        if (len_q != '1)
          len_q <= len_q + 1'b1;
        if (acc_cnt == FULL) begin
          out_valid <= 1'b1;
          out_data  <= acc;
          out_keep  <= '1;
          out_sof   <= ~sent_q;
          sent_q    <= 1'b1;
          acc       <= {{(DW-8){1'b0}}, rx_byte};
          acc_cnt   <= CW'(1);
        end else begin
          for (int i = 0; i < OUT_BYTES; i++)
            if (acc_cnt == CW'(i))
              acc[i*8 +: 8] <= rx_byte;
          acc_cnt <= acc_cnt + 1'b1;
        end
      end
      if (flush && acc_cnt != '0) begin
        out_valid <= 1'b1;
        out_data  <= acc;
        out_keep  <= keep_w;
        out_sof   <= ~sent_q;
        out_eof   <= 1'b1;
        out_err   <= err_q | odd;
        out_len   <= len_q;
        sent_q    <= 1'b1;
        acc_cnt   <= '0;
      end
    end
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic [2:0] link_q;

  // in-band status only between frames
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n)
      link_q <= '0;
    else if (stb && state_q == IDLE && !dv && !er)
      link_q <= {rx_byte[0], rx_byte[2:1]};
  end

  assign link_status = link_q;
`else
  assign link_status = 3'b000;
`endif

endmodule

// File: tb/tb_rgmii_rx_frontend.sv
// Directed bench for rgmii_rx_frontend with 4-byte and 1-byte word builds.
// Words are collected at the falling edge and checked after each frame.
module tb_rgmii_rx_frontend;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        s;
    logic        e;
    logic        r;
    logic [15:0] l;
  } wd_t;

`ifdef RGMII_INBAND_STATUS_EN
  localparam logic [2:0] LINK_EXP = 3'b110;
`else
  localparam logic [2:0] LINK_EXP = 3'b000;
`endif

  logic clk, reset_n, speed_1g, ctl;
  logic [3:0] rxd;
  logic [31:0] d4;
  logic [3:0] k4;
  logic v4, s4, e4, r4;
  logic [15:0] l4;
  logic [2:0] ls4;
  logic [7:0] d1;
  logic [0:0] k1;
  logic v1, s1, e1, r1;
  logic [15:0] l1;
  logic [2:0] ls1;

  wd_t q4[$];
  wd_t q1[$];
  logic [7:0] pl [0:15];
  int plen;
  logic [3:0] idle_nib;
  int vectors = 0;
  int errs = 0;

  rgmii_rx_frontend #(.OUT_BYTES(4)) u4 (
    .rx_clk(clk), .reset_n(reset_n), .speed_1g(speed_1g),
    .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl),
    .out_data(d4), .out_keep(k4), .out_valid(v4),
    .out_sof(s4), .out_eof(e4), .out_err(r4),
    .out_len(l4), .link_status(ls4)
  );

  rgmii_rx_frontend #(.OUT_BYTES(1)) u1 (
    .rx_clk(clk), .reset_n(reset_n), .speed_1g(speed_1g),
    .rgmii_rxd(rxd), .rgmii_rx_ctl(ctl),
    .out_data(d1), .out_keep(k1), .out_valid(v1),
    .out_sof(s1), .out_eof(e1), .out_err(r1),
    .out_len(l1), .link_status(ls1)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (v4)
      q4.push_back('{64'(d4), 8'(k4), s4, e4, r4, l4});
    if (v1)
      q1.push_back('{64'(d1), 8'(k1), s1, e1, r1, l1});
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ddr(input logic [7:0] b,
                     input logic v, input logic e);
    @(negedge clk); #2;
    rxd = b[3:0];
    ctl = v;
    @(posedge clk); #2;
    rxd = b[7:4];
    ctl = v ^ e;
  endtask

  task automatic idle(input int n);
    repeat (n) ddr({idle_nib, idle_nib}, 1'b0, 1'b0);
  endtask

  task automatic sdr(input logic [3:0] n, input logic v);
    @(negedge clk); #2;
    rxd = n;
    ctl = v;
  endtask

  task automatic frame1g(input int npre, input int er_idx);
    q4.delete();
    q1.delete();
    repeat (npre) ddr(8'h55, 1'b1, 1'b0);
    ddr(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < plen; i++)
      ddr(pl[i], 1'b1, i == er_idx);
    idle(6);
  endtask

  initial begin
    reset_n  = 1'b0;
    speed_1g = 1'b1;
    rxd      = 4'h0;
    ctl      = 1'b0;
    idle_nib = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 64'(v4), 0);
    check("rst_data", 64'(d4), 0);
    check("rst_len", 64'(l4), 0);
    check("rst_link", 64'(ls4), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    plen = 5;
    frame1g(7, -1);
    check("t1_cnt", 64'(q4.size()), 2);
    check("t1_w0_data", q4[0].d, 64'h04030201);
    check("t1_w0_keep", 64'(q4[0].k), 64'hF);
    check("t1_w0_sof", 64'(q4[0].s), 1);
    check("t1_w0_eof", 64'(q4[0].e), 0);
    check("t1_w1_data", q4[1].d, 64'h5);
    check("t1_w1_keep", 64'(q4[1].k), 64'h1);
    check("t1_w1_sof", 64'(q4[1].s), 0);
    check("t1_w1_eof", 64'(q4[1].e), 1);
    check("t1_w1_len", 64'(q4[1].l), 5);
    check("t1_w1_err", 64'(q4[1].r), 0);
    check("t1_b1_cnt", 64'(q1.size()), 5);
    check("t1_b1_last", q1[4].d, 64'h5);
    check("t1_b1_eof", 64'(q1[4].e), 1);

    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    plen = 8;
    frame1g(7, -1);
    check("t3_cnt", 64'(q4.size()), 2);
    check("t3_w1_data", q4[1].d, 64'h08070605);
    check("t3_w1_keep", 64'(q4[1].k), 64'hF);
    check("t3_w1_eof", 64'(q4[1].e), 1);
    check("t3_w1_len", 64'(q4[1].l), 8);

    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    plen = 5;
    frame1g(7, 2);
    check("t4_w0_data", q4[0].d, 64'h04030201);
    check("t4_w1_err", 64'(q4[1].r), 1);
    check("t4_w1_len", 64'(q4[1].l), 5);
    check("t4_b1_err", 64'(q1[4].r), 1);
    check("t4_b1_mid_err", 64'(q1[1].r), 0);

    frame1g(1, -1);
    check("t5_cnt4", 64'(q4.size()), 0);
    check("t5_cnt1", 64'(q1.size()), 0);

    q4.delete();
    q1.delete();
    repeat (7) ddr(8'h55, 1'b1, 1'b0);
    ddr(8'hD5, 1'b1, 1'b0);
    ddr(8'h11, 1'b1, 1'b0);
    ddr(8'h12, 1'b1, 1'b0);
    ddr(8'h13, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    ctl = 1'b0;
    rxd = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check("t6_rst_valid", 64'(v4), 0);
    reset_n = 1'b1;
    idle(4);
    check("t6_no_eof", 64'(q4.size()), 0);
    pl[0] = 8'hAA;
    plen = 1;
    frame1g(7, -1);
    check("t6_cnt", 64'(q4.size()), 1);
    check("t6_data", q4[0].d, 64'hAA);
    check("t6_keep", 64'(q4[0].k), 64'h1);
    check("t6_sofeof", 64'({q4[0].s, q4[0].e}), 64'h3);
    check("t6_len", 64'(q4[0].l), 1);
    check("t6_b1_cnt", 64'(q1.size()), 1);
    check("t6_b1_sofeof", 64'({q1[0].s, q1[0].e}), 64'h3);

    speed_1g = 1'b0;
    idle(4);
    q4.delete();
    q1.delete();
    repeat (7) begin
      sdr(4'h5, 1'b1);
      sdr(4'h5, 1'b1);
    end
    sdr(4'h5, 1'b1);
    sdr(4'hD, 1'b1);
    sdr(4'h1, 1'b1);
    sdr(4'h0, 1'b1);
    sdr(4'h2, 1'b1);
    sdr(4'h0, 1'b1);
    repeat (8) sdr(4'h0, 1'b0);
    check("t2_b1_cnt", 64'(q1.size()), 2);
    check("t2_b1_w0", q1[0].d, 64'h01);
    check("t2_b1_w0_sof", 64'({q1[0].s, q1[0].e}), 64'h2);
    check("t2_b1_w1", q1[1].d, 64'h02);
    check("t2_b1_w1_eof", 64'({q1[1].s, q1[1].e}), 64'h1);
    check("t2_b1_len", 64'(q1[1].l), 2);
    check("t2_b1_err", 64'(q1[1].r), 0);
    check("t2_w4_cnt", 64'(q4.size()), 1);
    check("t2_w4_data", q4[0].d, 64'h0201);
    check("t2_w4_keep", 64'(q4[0].k), 64'h3);
    check("t2_w4_len", 64'(q4[0].l), 2);

    q1.delete();
    repeat (7) begin
      sdr(4'h5, 1'b1);
      sdr(4'h5, 1'b1);
    end
    sdr(4'h5, 1'b1);
    sdr(4'hD, 1'b1);
    sdr(4'h7, 1'b1);
    sdr(4'h0, 1'b1);
    sdr(4'h9, 1'b1);
    repeat (8) sdr(4'h0, 1'b0);
    check("t2_odd_cnt", 64'(q1.size()), 1);
    check("t2_odd_err", 64'(q1[0].r), 1);
    check("t2_odd_len", 64'(q1[0].l), 1);

    speed_1g = 1'b1;
    idle(4);
    idle_nib = 4'hD;
    idle(3);
    #1;
    check("t7_link_idle", 64'(ls4), 64'(LINK_EXP));
    repeat (7) ddr(8'h55, 1'b1, 1'b0);
    ddr(8'hD5, 1'b1, 1'b0);
    ddr(8'h00, 1'b1, 1'b0);
    ddr(8'h00, 1'b1, 1'b0);
    #1;
    check("t7_link_frame", 64'(ls4), 64'(LINK_EXP));
    idle(4);
    check("t7_link_after", 64'(ls1), 64'(LINK_EXP));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
